// File: rtl/ca_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_e             - controller FSM encoding (ST_IDLE, ST_MEM_WAIT, ST_HALT)
//   REG_IDX_W           - architectural register index width
//   DEFAULT_MEM_TIMEOUT - default MEM_WAIT cycle budget before the error halt
package ca_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the stall/flush sequencer.
//   master : datapath side, drives hazard sources/destinations, branch and SRAM handshake,
//            receives freeze/flush controls, error flag and stall counter.
//   slave  : pipeline_ctrl side, the mirror image.
// Parameter CNT_W sizes stall_cnt and must match the controller's CNT_W.
interface pipeline_ctrl_if
  import ca_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [REG_IDX_W-1:0] src1;
  logic [REG_IDX_W-1:0] src2;
  logic                 use_src1;
  logic                 two_src;
  logic [REG_IDX_W-1:0] exe_dest;
  logic                 exe_wb_en;
  logic                 exe_mem_r;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_wb_en;
  logic                 b_taken;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 freeze_front;
  logic                 freeze_back;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 mem_err;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output src1, src2, use_src1, two_src, exe_dest, exe_wb_en, exe_mem_r,
           mem_dest, mem_wb_en, b_taken, mem_req, mem_ready,
    input  freeze_front, freeze_back, flush_if_id, flush_id_ex, mem_err, stall_cnt
  );

  modport slave (
    input  src1, src2, use_src1, two_src, exe_dest, exe_wb_en, exe_mem_r,
           mem_dest, mem_wb_en, b_taken, mem_req, mem_ready,
    output freeze_front, freeze_back, flush_if_id, flush_id_ex, mem_err, stall_cnt
  );

endinterface

// File: rtl/hazard_unit.sv
// Combinational RAW hazard detector for the instruction in ID.
//   src1/src2, use_src1/two_src : ID sources and their use flags
//   exe_dest/exe_wb_en/exe_mem_r : producer in ID/EX
//   mem_dest/mem_wb_en           : producer in EX/MEM
//   hz                           : ID must stall one cycle
// Build option FORWARDING_EN: only a load in ID/EX stalls (forwarding covers the rest);
// otherwise any pending write in ID/EX or EX/MEM to a used source stalls.
module hazard_unit
  import ca_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 use_src1,
  input  logic                 two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hz
);

  logic exe_match;
  assign exe_match = (use_src1 && (src1 == exe_dest)) || (two_src && (src2 == exe_dest));

`ifdef FORWARDING_EN
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_wb_en};
  assign hz = exe_wb_en && exe_mem_r && exe_match;
`else
  logic mem_match;
  assign mem_match = (use_src1 && (src1 == mem_dest)) || (two_src && (src2 == mem_dest));
  // exe_mem_r is irrelevant when nothing is forwarded
  logic unused_mem_r;
  assign unused_mem_r = exe_mem_r;
  assign hz = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pipeline_ctrl_if.slave - hazard inputs, branch, SRAM handshake in;
//              freeze_front/back, flush_if_id/id_ex, mem_err, stall_cnt out
// Parameters: MEM_TIMEOUT (MEM_WAIT cycle budget), CNT_W (stall counter width).
// Build option FORWARDING_EN selects the load-use-only hazard rule in hazard_unit.
module pipeline_ctrl
  import ca_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  // Last MEM_WAIT cycle that may still see mem_ready before halting
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [WaitW-1:0] wait_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hz;
  logic mem_stall;
  logic freeze_front, freeze_back, flush_if_id, flush_id_ex;

  hazard_unit u_hazard (
    .src1      (bus.src1),
    .src2      (bus.src2),
    .use_src1  (bus.use_src1),
    .two_src   (bus.two_src),
    .exe_dest  (bus.exe_dest),
    .exe_wb_en (bus.exe_wb_en),
    .exe_mem_r (bus.exe_mem_r),
    .mem_dest  (bus.mem_dest),
    .mem_wb_en (bus.mem_wb_en),
    .hz        (hz)
  );

  always_comb begin
    mem_stall = 1'b1;
    case (state_q)
      ST_IDLE:     mem_stall = bus.mem_req && !bus.mem_ready;
      ST_MEM_WAIT: mem_stall = !bus.mem_ready;
      default:     mem_stall = 1'b1;
    endcase
  end

  // Memory stall beats branch beats hazard. A branch seen during a memory stall sits
  // in the frozen EXE stage and gets its flush on the release cycle.
  always_comb begin
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (mem_stall) begin
      freeze_front = 1'b1;
      freeze_back  = 1'b1;
    end else if (bus.b_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hz) begin
      freeze_front = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if ((freeze_front || freeze_back) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req && !bus.mem_ready) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          wait_q <= wait_q + 1'b1;
          if (bus.mem_ready) begin
            state_q <= ST_IDLE;
          end else if (wait_q == WaitLast) begin
            state_q   <= ST_HALT;
            mem_err_q <= 1'b1;
          end
        end
        ST_HALT: mem_err_q <= 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.freeze_front = freeze_front;
  assign bus.freeze_back  = freeze_back;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import ca_pkg::*;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef FORWARDING_EN
  localparam logic [4:0] NOFWD_STALL = 5'b00000;
`else
  localparam logic [4:0] NOFWD_STALL = 5'b10010;
`endif

  // ctl = {freeze_front, freeze_back, flush_if_id, flush_id_ex, mem_err}
  typedef struct {
    logic [3:0] src1, src2;
    logic       use_src1, two_src;
    logic [3:0] exe_dest;
    logic       exe_wb_en, exe_mem_r;
    logic [3:0] mem_dest;
    logic       mem_wb_en, b_taken, mem_req, mem_ready;
    logic [4:0] ctl;
  } stim_t;

  typedef struct {
    string      name;
    logic [4:0] ctl;
    int         cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_cnt;
  exp_t sb[$];

  pipeline_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic u1,
                               input logic ts, input logic [3:0] ed, input logic ewb,
                               input logic emr, input logic [3:0] md, input logic mwb,
                               input logic bt, input logic rq, input logic rdy,
                               input logic [4:0] ctl);
    stim_t s;
    s.src1 = s1; s.src2 = s2; s.use_src1 = u1; s.two_src = ts;
    s.exe_dest = ed; s.exe_wb_en = ewb; s.exe_mem_r = emr;
    s.mem_dest = md; s.mem_wb_en = mwb;
    s.b_taken = bt; s.mem_req = rq; s.mem_ready = rdy; s.ctl = ctl;
    return s;
  endfunction

  function automatic logic [4:0] obs_ctl();
    return {bus.freeze_front, bus.freeze_back, bus.flush_if_id, bus.flush_id_ex, bus.mem_err};
  endfunction

  // Drives one cycle of stimulus on the falling edge and queues its expected outcome.
  task automatic drive(input stim_t s, input string name);
    exp_t e;
    @(negedge clk);
    bus.src1 = s.src1; bus.src2 = s.src2; bus.use_src1 = s.use_src1; bus.two_src = s.two_src;
    bus.exe_dest = s.exe_dest; bus.exe_wb_en = s.exe_wb_en; bus.exe_mem_r = s.exe_mem_r;
    bus.mem_dest = s.mem_dest; bus.mem_wb_en = s.mem_wb_en; bus.b_taken = s.b_taken;
    bus.mem_req = s.mem_req; bus.mem_ready = s.mem_ready;
    e.name = name;
    e.ctl  = s.ctl;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    // stall counter model: counts cycles with any freeze expected, saturating
    if ((s.ctl[4] || s.ctl[3]) && exp_cnt < int'(CNT_MAX)) exp_cnt++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.src1 = '0; bus.src2 = '0; bus.use_src1 = 1'b0; bus.two_src = 1'b0;
    bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_r = 1'b0;
    bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.b_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL reset ctl got=%b want=%b", obs_ctl(), 5'b00000);
    end
    checks++;
    if (bus.stall_cnt !== TB_CNT_W'(0)) begin
      errors++;
      $display("FAIL reset stall_cnt got=%0d want=0", bus.stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t t[9];
    exp_t  e;
    t[0] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 5'b10010); // load R3, ID reads R3
    t[1] = mk(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 5'b00000); // bubble gone
    t[2] = mk(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 5'b10010); // match on src2
    t[3] = mk(0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 5'b00000); // src2 unused
    t[4] = mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 5'b00000); // src1 unused
    t[5] = mk(3, 0, 1, 0, 7, 0, 0, 3, 1, 0, 0, 0, NOFWD_STALL); // ADD in EX/MEM
    t[6] = mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, NOFWD_STALL); // ADD in ID/EX
    t[7] = mk(3, 0, 1, 0, 7, 0, 0, 3, 0, 0, 0, 0, 5'b00000); // EX/MEM no write-back
    t[8] = mk(4, 2, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 5'b00000); // load, other regs
    for (int i = 0; i < 9; i++) begin
      drive(t[i], $sformatf("load_use[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    stim_t t[4];
    exp_t  e;
    t[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00110); // branch alone
    t[1] = mk(3, 0, 1, 0, 3, 1, 1, 3, 1, 1, 0, 0, 5'b00110); // branch over hazard
    t[2] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 5'b10010); // hazard alone
    t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      drive(t[i], $sformatf("branch[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
  endtask

  // Three SRAM wait cycles, with a branch and hazard arriving during the stall.
  task automatic test_mem_wait();
    stim_t t[5];
    exp_t  e;
    t[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000);
    t[1] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1, 0, 5'b11000);
    t[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11000);
    t[3] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1, 1, 5'b00110); // release: held branch flushes
    t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000); // back in IDLE
    for (int i = 0; i < 5; i++) begin
      drive(t[i], $sformatf("mem_wait[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_zero_wait();
    stim_t t[6];
    exp_t  e;
    t[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);
    t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);
    t[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000); // proves state was IDLE
    t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);
    t[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int i = 0; i < 6; i++) begin
      drive(t[i], $sformatf("zero_wait[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
  endtask

  // MEM_TIMEOUT=4: ready on the last allowed wait cycle still escapes; otherwise HALT.
  task automatic test_timeout();
    stim_t t[13];
    exp_t  e;
    for (int i = 0; i < 4; i++) t[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000);
    t[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000);
    t[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int i = 6; i < 11; i++) t[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000);
    t[11] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 1, 5'b11001); // HALT ignores ready/branch
    t[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001);
    for (int i = 0; i < 13; i++) begin
      drive(t[i], $sformatf("timeout[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
    // Reset mid-HALT, away from any clock edge
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    checks++;
    if (obs_ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL halt_reset ctl got=%b want=%b", obs_ctl(), 5'b00000);
    end
    checks++;
    if (bus.stall_cnt !== TB_CNT_W'(0)) begin
      errors++;
      $display("FAIL halt_reset stall_cnt got=%0d want=0", bus.stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 23; i++) begin
      if (i < 20) s = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 5'b10010);
      else        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
      drive(s, $sformatf("saturate[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name, obs_ctl(), e.ctl);
      end
      checks++;
      if (int'(bus.stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
    checks++;
    if (int'(bus.stall_cnt) != int'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate_final stall_cnt got=%0d want=%0d", bus.stall_cnt, CNT_MAX);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_zero_wait();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage ARM-subset pipeline. Watches register-read sources in ID, destinations in the ID/EX and EX/MEM registers, the EXE branch decision and the MEM-stage SRAM handshake. Drives freeze and flush for the IF, IF/ID, ID/EX, EX/MEM and MEM/WB registers. The ID/EX register's `flush` input is driven from `flush_id_ex`.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before the error halt (1..65535).
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `src1`  in  4: Rn index of the instruction in ID.
- `src2`  in  4: Rm/Rd index of the instruction in ID.
- `use_src1`  in  1: ID instruction reads `src1`.
- `two_src`  in  1: ID instruction reads `src2`.
- `exe_dest`  in  4: ID/EX destination.
- `exe_wb_en`  in  1: ID/EX write-back enable.
- `exe_mem_r`  in  1: ID/EX instruction is a load.
- `mem_dest`  in  4: EX/MEM destination.
- `mem_wb_en`  in  1: EX/MEM write-back enable.
- `b_taken`  in  1: branch taken, from the EXE stage.
- `mem_req`  in  1: EX/MEM holds a load or store.
- `mem_ready`  in  1: SRAM access complete this cycle.
- `freeze_front`  out  1: hold PC and IF/ID.
- `freeze_back`  out  1: hold ID/EX, EX/MEM and MEM/WB.
- `flush_if_id`  out  1: clear IF/ID.
- `flush_id_ex`  out  1: insert a bubble into ID/EX.
- `mem_err`  out  1: sticky timeout flag.
- `stall_cnt`  out  CNT_W: saturating count of cycles with any freeze asserted.

## Operation

- The FSM has three states: IDLE, MEM_WAIT and HALT.
- Data hazard (`hz`) is combinational and means a source matches a pending destination:
  - A source counts only when it is used: `src1` when `use_src1`, `src2` when `two_src`.
  - With forwarding: `hz` = `exe_wb_en & exe_mem_r` and (used `src1` == `exe_dest` or used `src2` == `exe_dest`).
  - Without forwarding: `hz` = used source matches `exe_dest` with `exe_wb_en`, or matches `mem_dest` with `mem_wb_en`.
- `mem_stall` = (IDLE & `mem_req` & ~`mem_ready`) | (MEM_WAIT & ~`mem_ready`) | HALT.
- Outputs, in priority order:
  1. `mem_stall`: `freeze_front`=1 and `freeze_back`=1. Both flush outputs are 0, even if `b_taken` or `hz` is high.
  2. `b_taken`: `flush_if_id`=1 and `flush_id_ex`=1, with no freeze. The branch overrides `hz`, because the stalled instruction is squashed anyway.
  3. `hz`: `freeze_front`=1 and `flush_id_ex`=1, inserting a bubble.
  4. Otherwise all control outputs are 0.
- A branch that arrives during a memory stall is held in the frozen EXE stage. Its flush is issued on the release cycle.
- FSM transitions:
  - IDLE → MEM_WAIT when `mem_req & ~mem_ready`. A zero-wait access (`mem_req & mem_ready`) stays in IDLE.
  - MEM_WAIT → IDLE when `mem_ready`.
  - MEM_WAIT → HALT when the wait counter reaches `MEM_TIMEOUT` without `mem_ready`. If `mem_ready` is high on that same cycle, go to IDLE instead.
  - HALT is absorbing: `mem_err`=1 and both freezes stay at 1 until `rst`.
- Wait counter:
  - Clears on entry to MEM_WAIT.
  - Increments once per MEM_WAIT cycle.
  - Width is `$clog2(MEM_TIMEOUT+1)`.
- `stall_cnt`:
  - Increments on every cycle where `freeze_front | freeze_back` is high.
  - Saturates at all-ones and never wraps.

## Timing

- Freeze and flush outputs are combinational from the current state and inputs, valid in the same cycle.
- State, wait counter, `mem_err` and `stall_cnt` are registered.
- A load-use dependency costs exactly 1 bubble with forwarding. Without forwarding it costs up to 2 bubbles, depending on whether the producer is in ID/EX or EX/MEM.
- An SRAM access with N wait cycles (N ≥ 1) freezes the pipeline for exactly N cycles. The pipeline advances on the edge where `mem_ready` is high.
- Reset values: state=IDLE, wait counter=0, `mem_err`=0, `stall_cnt`=0. Freeze and flush outputs then follow the rules above with state=IDLE.
- A reset in MEM_WAIT or HALT returns to IDLE asynchronously. No stale freeze is carried past reset.

## Configuration

- `FORWARDING_EN` defined: load-use-only hazard rule, for use with the forwarding unit.
- `FORWARDING_EN` undefined: full RAW hazard rule against both ID/EX and EX/MEM destinations.
- The `mem_dest` and `mem_wb_en` ports exist in both builds. With forwarding they are ignored.

## Structure

- Shared package `ca_pkg` holds:
  - the FSM state encoding (`ST_IDLE`, `ST_MEM_WAIT`, `ST_HALT`, 2 bits);
  - the register index width (4);
  - the default `MEM_TIMEOUT`.
- Sub-module `hazard_unit` holds the purely combinational `hz` logic, including the `FORWARDING_EN` selection.
- The FSM, counters and output priority mux live in `pipeline_ctrl`.

## Test plan

- Load-use with forwarding: load into R3 in ID/EX (`exe_mem_r`=1, `exe_wb_en`=1, `exe_dest`=3) while ID uses `src1`=3 → one cycle of `freeze_front`=1 and `flush_id_ex`=1, then 0. Without forwarding, an ADD producer in EX/MEM (`mem_dest`=3) → a stall is also raised.
- Branch over hazard: `b_taken`=1 and `hz`=1 together → `flush_if_id`=1, `flush_id_ex`=1, `freeze_front`=0.
- SRAM with 3 wait cycles: `mem_req`=1, `mem_ready` low for 3 cycles then high → both freezes high for exactly 3 cycles, `stall_cnt` advances by 3, state returns to IDLE.
- Zero-wait access: `mem_req`=1 and `mem_ready`=1 in the same cycle → no freeze, state stays IDLE.
- Timeout: `MEM_TIMEOUT`=4 with `mem_ready` never asserted → HALT after 4 wait cycles; `mem_err`=1 and freezes held. Asserting `rst` mid-HALT → all outputs 0 and state IDLE immediately.
- Counter saturation: `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15 and held.
